// File: rtl/fan_alu_sequencer.sv
// fan_alu_sequencer
//   Classifies a temperature into a fan speed by time-sharing an external
//   8-bit ALU. Each sample runs IDLE -> CMP_LO -> CMP_HI -> DECIDE, one cycle
//   per state. Two SUB operations compare the latched temperature against the
//   low and high thresholds. Hysteresis and a consecutive-sample debounce are
//   applied before fan_speed moves.
//
// Ports
//   clk           in   system clock
//   rst_n         in   asynchronous active-low reset
//   temp_in       in   [7:0]  unsigned temperature
//   force_sample  in   one-cycle request for an immediate sample
//   alu_result    in   [15:0] ALU result; only the sign bit is consumed
//   alu_opcode    out  [2:0]  3'b001 (SUB) while comparing, 3'b000 otherwise
//   alu_op1       out  [7:0]  ALU operand 1 (latched temperature)
//   alu_op2       out  [7:0]  ALU operand 2 (threshold)
//   fan_speed     out  [1:0]  00 low, 01 medium, 10 high
//   speed_changed out  one-cycle pulse when fan_speed updates
//   busy          out  high while a sample sequence is in progress
module fan_alu_sequencer #(
    parameter int unsigned LOW_THR    = 20,
    parameter int unsigned HIGH_THR   = 40,
    parameter int unsigned HYST       = 2,
    parameter int unsigned SAMPLE_DIV = 1000,
    parameter int unsigned STABLE_CNT = 3
) (
    input  logic        clk,
    input  logic        rst_n,
    input  logic [7:0]  temp_in,
    input  logic        force_sample,
    input  logic [15:0] alu_result,
    output logic [2:0]  alu_opcode,
    output logic [7:0]  alu_op1,
    output logic [7:0]  alu_op2,
    output logic [1:0]  fan_speed,
    output logic        speed_changed,
    output logic        busy
);

    localparam int unsigned DIV_W = $clog2(SAMPLE_DIV);
    localparam logic [DIV_W-1:0] DIV_LAST = DIV_W'(SAMPLE_DIV - 1);
    localparam logic [7:0] LO_UP   = 8'(LOW_THR);
    localparam logic [7:0] LO_DOWN = 8'(LOW_THR - HYST);
    localparam logic [7:0] HI_UP   = 8'(HIGH_THR);
    localparam logic [7:0] HI_DOWN = 8'(HIGH_THR - HYST);
    localparam logic [3:0] CNT_MAX = 4'(STABLE_CNT);
    localparam logic [2:0] OP_SUB  = 3'b001;
    localparam logic [2:0] OP_NONE = 3'b000;

    typedef enum logic [1:0] {IDLE, CMP_LO, CMP_HI, DECIDE} state_t;

    state_t           state_reg, state_next;
    logic [DIV_W-1:0] div_reg, div_next;
    logic [7:0]       t_reg, t_next;
    logic             below_lo_reg, below_hi_reg;
    logic [1:0]       pending_reg, pending_next;
    logic [3:0]       stable_cnt_reg, stable_cnt_next;
    logic [1:0]       fan_speed_reg, fan_speed_next;
    logic             speed_changed_reg, speed_changed_next;
    logic             busy_reg, busy_next;
    logic [2:0]       alu_opcode_reg, alu_opcode_next;
    logic [7:0]       alu_op1_reg, alu_op1_next;
    logic [7:0]       alu_op2_reg, alu_op2_next;

    logic       tick;
    logic [7:0] thr_lo, thr_hi;
    logic [1:0] cand;

    // Only the sign of the subtraction matters.
    logic unused_alu_bits;
    assign unused_alu_bits = &{1'b0, alu_result[14:0]};

    assign tick    = (div_reg == DIV_LAST);
    assign div_next = tick ? '0 : div_reg + 1'b1;

    // fan_speed only changes on the DECIDE->IDLE edge, so these thresholds
    // stay constant for the whole compare sequence.
    assign thr_lo = (fan_speed_reg != 2'b00) ? LO_DOWN : LO_UP;
    assign thr_hi = (fan_speed_reg == 2'b10) ? HI_DOWN : HI_UP;

    // State register
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_reg <= IDLE;
        end else begin
            state_reg <= state_next;
        end
    end

    // Next-state logic; triggers arriving while busy are dropped.
    always_comb begin
        state_next = state_reg;
        case (state_reg)
            IDLE:    if (tick || force_sample) state_next = CMP_LO;
            CMP_LO:  state_next = CMP_HI;
            CMP_HI:  state_next = DECIDE;
            DECIDE:  state_next = IDLE;
            default: state_next = IDLE;
        endcase
    end

    // Datapath and debounce decisions
    always_comb begin
        t_next             = t_reg;
        pending_next       = pending_reg;
        stable_cnt_next    = stable_cnt_reg;
        fan_speed_next     = fan_speed_reg;
        speed_changed_next = 1'b0;
        cand               = below_lo_reg ? 2'b00 : (below_hi_reg ? 2'b01 : 2'b10);

        if (state_reg == IDLE && state_next == CMP_LO) begin
            t_next = temp_in;
        end

        if (state_reg == DECIDE) begin
            if (cand == pending_reg) begin
                stable_cnt_next = (stable_cnt_reg >= CNT_MAX) ? CNT_MAX : stable_cnt_reg + 1'b1;
            end else begin
                pending_next    = cand;
                stable_cnt_next = 4'd1;
            end
            if (stable_cnt_next == CNT_MAX && cand != fan_speed_reg) begin
                fan_speed_next     = cand;
                speed_changed_next = 1'b1;
            end
        end
    end

    // Output logic: decoded from the next state so the registered ALU bus
    // lines up with the state that uses it.
    always_comb begin
        alu_opcode_next = OP_NONE;
        alu_op1_next    = 8'd0;
        alu_op2_next    = 8'd0;
        busy_next       = (state_next != IDLE);
        case (state_next)
            CMP_LO: begin
                alu_opcode_next = OP_SUB;
                alu_op1_next    = t_next;
                alu_op2_next    = thr_lo;
            end
            CMP_HI: begin
                alu_opcode_next = OP_SUB;
                alu_op1_next    = t_next;
                alu_op2_next    = thr_hi;
            end
            default: ;
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            div_reg           <= '0;
            t_reg             <= 8'd0;
            below_lo_reg      <= 1'b0;
            below_hi_reg      <= 1'b0;
            pending_reg       <= 2'b00;
            stable_cnt_reg    <= 4'd0;
            fan_speed_reg     <= 2'b00;
            speed_changed_reg <= 1'b0;
            busy_reg          <= 1'b0;
            alu_opcode_reg    <= OP_NONE;
            alu_op1_reg       <= 8'd0;
            alu_op2_reg       <= 8'd0;
        end else begin
            div_reg           <= div_next;
            t_reg             <= t_next;
            if (state_reg == CMP_LO) below_lo_reg <= alu_result[15];
            if (state_reg == CMP_HI) below_hi_reg <= alu_result[15];
            pending_reg       <= pending_next;
            stable_cnt_reg    <= stable_cnt_next;
            fan_speed_reg     <= fan_speed_next;
            speed_changed_reg <= speed_changed_next;
            busy_reg          <= busy_next;
            alu_opcode_reg    <= alu_opcode_next;
            alu_op1_reg       <= alu_op1_next;
            alu_op2_reg       <= alu_op2_next;
        end
    end

    assign alu_opcode    = alu_opcode_reg;
    assign alu_op1       = alu_op1_reg;
    assign alu_op2       = alu_op2_reg;
    assign fan_speed     = fan_speed_reg;
    assign speed_changed = speed_changed_reg;
    assign busy          = busy_reg;

endmodule
